turn_sched: RTL and testbench



---
 rtl/game_pkg.sv | 41 ++++
 rtl/lfsr16.sv | 35 +++
 rtl/turn_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_turn_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared types, widths and helpers for the turn sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int HP_W    = 7;
    localparam int FORCE_W = 10;
    localparam int WIND_W  = 7;

    localparam logic [WIND_W-1:0] WIND_CALM = 7'd50;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AIM    = 3'd1,
        ST_CHARGE = 3'd2,
        ST_FLIGHT = 3'd3,
        ST_SETTLE = 3'd4,
        ST_OVER   = 3'd5
    } turn_state_t;

    typedef enum logic {
        PL_CAT = 1'b0,
        PL_DOG = 1'b1
    } player_t;

    function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp,
                                                     input logic [HP_W-1:0] dmg);
        return (hp > dmg) ? hp - dmg : '0;
    endfunction

    function automatic logic [WIND_W-1:0] wind_mod101(input logic [WIND_W-1:0] v);
        return (v >= 7'd101) ? v - 7'd101 : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Fibonacci LFSR (taps 16,15,13,4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/turn_sched.sv
// ============================================================================
// Module      : turn_sched
// Description : Two-player turn sequencer: charge, throw, settle, damage, wind.
//               Define WIND_RANDOM_EN for LFSR-driven wind; otherwise calm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_sched
    import game_pkg::*;
#(
    parameter int unsigned HP_INIT        = 100,
    parameter int unsigned DAMAGE         = 20,
    parameter int unsigned FORCE_MAX      = 1000,
    parameter int unsigned FORCE_STEP     = 5,
    parameter int unsigned TICK_CYCLES    = 65000,
    parameter int unsigned FLIGHT_TIMEOUT = 200_000_000,
    parameter int unsigned SETTLE_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                btn,
    input  logic                done_cat,
    input  logic                done_dog,
    input  logic                hit_cat,
    input  logic                hit_dog,
    output logic                enable_cat,
    output logic                enable_dog,
    output logic [FORCE_W-1:0]  throw_force,
    output logic [WIND_W-1:0]   wind,
    output logic                turn,
    output logic [HP_W-1:0]     hp_cat,
    output logic [HP_W-1:0]     hp_dog,
    output logic                game_over,
    output logic                winner
);

    localparam int TICK_W   = (TICK_CYCLES > 1)    ? $clog2(TICK_CYCLES)    : 1;
    localparam int TMO_W    = (FLIGHT_TIMEOUT > 1) ? $clog2(FLIGHT_TIMEOUT) : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1)  ? $clog2(SETTLE_CYCLES)  : 1;

    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(FLIGHT_TIMEOUT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [HP_W-1:0]     HP_START    = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0]     HP_DAMAGE   = HP_W'(DAMAGE);
    localparam logic [FORCE_W:0]    FORCE_STEP_X = (FORCE_W+1)'(FORCE_STEP);
    localparam logic [FORCE_W:0]    FORCE_MAX_X  = (FORCE_W+1)'(FORCE_MAX);

    turn_state_t         state_q, state_d;
    player_t             turn_q, turn_d;
    logic [FORCE_W-1:0]  force_q, force_d;
    logic [WIND_W-1:0]   wind_q, wind_d;
    logic [HP_W-1:0]     hp_cat_q, hp_cat_d;
    logic [HP_W-1:0]     hp_dog_q, hp_dog_d;
    logic                winner_q, winner_d;
    logic                game_over_q, game_over_d;
    logic                enable_cat_q, enable_cat_d;
    logic                enable_dog_q, enable_dog_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                btn_prev_q;

    logic                btn_rise;
    logic                btn_fall;
    logic                active_done;
    logic                hit_window;
    logic [FORCE_W:0]    force_sum;
    logic [FORCE_W-1:0]  force_ticked;
    logic [WIND_W-1:0]   wind_next;

`ifdef WIND_RANDOM_EN
    logic [15:0] lfsr;
    logic        lfsr_unused;

    lfsr16 #(
        .SEED (16'hACE1)
    ) u_lfsr16 (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:7];
    assign wind_next   = wind_mod101(lfsr[6:0]);
`else
    assign wind_next = WIND_CALM;
`endif

    assign btn_rise    = btn & ~btn_prev_q;
    assign btn_fall    = ~btn & btn_prev_q;
    assign active_done = (turn_q == PL_CAT) ? done_cat : done_dog;
    // Hits land late relative to done, so the first SETTLE cycle still counts.
    assign hit_window  = (state_q == ST_FLIGHT) ||
                         ((state_q == ST_SETTLE) && (settle_cnt_q == '0));
    assign force_sum    = {1'b0, force_q} + FORCE_STEP_X;
    assign force_ticked = (force_sum >= FORCE_MAX_X) ? FORCE_MAX_X[FORCE_W-1:0]
                                                     : force_sum[FORCE_W-1:0];

    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        force_d      = force_q;
        wind_d       = wind_q;
        hp_cat_d     = hp_cat_q;
        hp_dog_d     = hp_dog_q;
        winner_d     = winner_q;
        tick_cnt_d   = tick_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        settle_cnt_d = settle_cnt_q;

        if (hit_window && hit_cat) begin
            hp_cat_d = hp_after_hit(hp_cat_q, HP_DAMAGE);
        end
        if (hit_window && hit_dog) begin
            hp_dog_d = hp_after_hit(hp_dog_q, HP_DAMAGE);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_AIM;
                    hp_cat_d = HP_START;
                    hp_dog_d = HP_START;
                    turn_d   = PL_CAT;
                    force_d  = '0;
                end
            end
            ST_AIM: begin
                force_d = '0;
                if (btn_rise) begin
                    state_d    = ST_CHARGE;
                    tick_cnt_d = '0;
                end
            end
            ST_CHARGE: begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    force_d    = force_ticked;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
                if (btn_fall) begin
                    state_d   = ST_FLIGHT;
                    tmo_cnt_d = '0;
                end
            end
            ST_FLIGHT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (active_done || (tmo_cnt_q == TMO_LAST)) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                settle_cnt_d = settle_cnt_q + 1'b1;
                if (settle_cnt_q == SETTLE_LAST) begin
                    if ((hp_cat_q == '0) || (hp_dog_q == '0)) begin
                        state_d = ST_OVER;
                        if (hp_cat_q != '0) begin
                            winner_d = PL_CAT;
                        end else if (hp_dog_q != '0) begin
                            winner_d = PL_DOG;
                        end else begin
                            winner_d = turn_q;
                        end
                    end else begin
                        state_d = ST_AIM;
                        turn_d  = (turn_q == PL_CAT) ? PL_DOG : PL_CAT;
                        force_d = '0;
                        wind_d  = wind_next;
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d  = ST_IDLE;
                    hp_cat_d = HP_START;
                    hp_dog_d = HP_START;
                    turn_d   = PL_CAT;
                    winner_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Decoded from next state so enables rise with the FLIGHT state itself.
        enable_cat_d = (state_d == ST_FLIGHT) && (turn_d == PL_CAT);
        enable_dog_d = (state_d == ST_FLIGHT) && (turn_d == PL_DOG);
        game_over_d  = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            turn_q       <= PL_CAT;
            force_q      <= '0;
            wind_q       <= WIND_CALM;
            hp_cat_q     <= HP_START;
            hp_dog_q     <= HP_START;
            winner_q     <= 1'b0;
            game_over_q  <= 1'b0;
            enable_cat_q <= 1'b0;
            enable_dog_q <= 1'b0;
            tick_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            settle_cnt_q <= '0;
            btn_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            turn_q       <= turn_d;
            force_q      <= force_d;
            wind_q       <= wind_d;
            hp_cat_q     <= hp_cat_d;
            hp_dog_q     <= hp_dog_d;
            winner_q     <= winner_d;
            game_over_q  <= game_over_d;
            enable_cat_q <= enable_cat_d;
            enable_dog_q <= enable_dog_d;
            tick_cnt_q   <= tick_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            btn_prev_q   <= btn;
        end
    end

    assign enable_cat  = enable_cat_q;
    assign enable_dog  = enable_dog_q;
    assign throw_force = force_q;
    assign wind        = wind_q;
    assign turn        = turn_q;
    assign hp_cat      = hp_cat_q;
    assign hp_dog      = hp_dog_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_turn_sched.sv
// ============================================================================
// Module      : tb_turn_sched
// Description : Directed vector table, corner sequences and a randomized run
//               against a behavioural game model for turn_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_turn_sched;

    localparam int TICK   = 10;
    localparam int TMO    = 50;
    localparam int SETTLE = 4;
    localparam int HPI    = 100;
    localparam int DMG    = 20;
    localparam int FMAX   = 1000;
    localparam int FSTEP  = 5;

    localparam int P_IDLE = 0, P_AIM = 1, P_CHARGE = 2, P_FLIGHT = 3, P_SETTLE = 4, P_OVER = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, btn = 1'b0;
    logic       done_cat = 1'b0, done_dog = 1'b0, hit_cat = 1'b0, hit_dog = 1'b0;
    logic       enable_cat, enable_dog, turn, game_over, winner;
    logic [9:0] throw_force;
    logic [6:0] wind, hp_cat, hp_dog;

    always #5 clk = ~clk;

    turn_sched #(
        .HP_INIT        (HPI),
        .DAMAGE         (DMG),
        .FORCE_MAX      (FMAX),
        .FORCE_STEP     (FSTEP),
        .TICK_CYCLES    (TICK),
        .FLIGHT_TIMEOUT (TMO),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .btn         (btn),
        .done_cat    (done_cat),
        .done_dog    (done_dog),
        .hit_cat     (hit_cat),
        .hit_dog     (hit_dog),
        .enable_cat  (enable_cat),
        .enable_dog  (enable_dog),
        .throw_force (throw_force),
        .wind        (wind),
        .turn        (turn),
        .hp_cat      (hp_cat),
        .hp_dog      (hp_dog),
        .game_over   (game_over),
        .winner      (winner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit s, input bit b, input bit dc, input bit dd,
                          input bit hc, input bit hd);
        start = s; btn = b; done_cat = dc; done_dog = dd; hit_cat = hc; hit_dog = hd;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".en_cat"}, 32'(enable_cat), 0);
        chk({tag, ".en_dog"}, 32'(enable_dog), 0);
        chk({tag, ".force"},  32'(throw_force), 0);
        chk({tag, ".wind"},   32'(wind), 50);
        chk({tag, ".turn"},   32'(turn), 0);
        chk({tag, ".hp_cat"}, 32'(hp_cat), HPI);
        chk({tag, ".hp_dog"}, 32'(hp_dog), HPI);
        chk({tag, ".over"},   32'(game_over), 0);
        chk({tag, ".winner"}, 32'(winner), 0);
    endtask

    // ---------------- behavioural game model ----------------
    int          m_ph, m_force, m_turn, m_wind, m_win, m_tick, m_fl, m_st;
    int          m_hp [2];
    bit          m_prev;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        bit fb;
        fb = v[16-16+15] ^ v[15-1] ^ v[13-1] ^ v[4-1];
        return {v[14:0], fb};
    endfunction

    task automatic m_reset();
        m_ph = P_IDLE; m_force = 0; m_turn = 0; m_wind = 50; m_win = 0;
        m_tick = 0; m_fl = 0; m_st = 0; m_hp[0] = HPI; m_hp[1] = HPI;
        m_prev = 1'b0; m_lfsr = 16'hACE1;
    endtask

    task automatic m_step();
        bit rise, fall, hit_ok, d_act;
        int nxt;
        rise   = btn && !m_prev;
        fall   = !btn && m_prev;
        hit_ok = (m_ph == P_FLIGHT) || (m_ph == P_SETTLE && m_st == 0);
        d_act  = (m_turn == 0) ? done_cat : done_dog;
        nxt    = m_ph;
        case (m_ph)
            P_IDLE: if (start) begin
                nxt = P_AIM; m_hp[0] = HPI; m_hp[1] = HPI; m_turn = 0; m_force = 0;
            end
            P_AIM: begin
                m_force = 0;
                if (rise) begin nxt = P_CHARGE; m_tick = 0; end
            end
            P_CHARGE: begin
                m_tick++;
                if (m_tick == TICK) begin
                    m_tick  = 0;
                    m_force = (m_force + FSTEP > FMAX) ? FMAX : m_force + FSTEP;
                end
                if (fall) begin nxt = P_FLIGHT; m_fl = 0; end
            end
            P_FLIGHT: begin
                m_fl++;
                if (d_act || m_fl == TMO) begin nxt = P_SETTLE; m_st = 0; end
            end
            P_SETTLE: begin
                m_st++;
                if (m_st == SETTLE) begin
                    if (m_hp[0] == 0 || m_hp[1] == 0) begin
                        nxt   = P_OVER;
                        m_win = (m_hp[0] != 0) ? 0 : (m_hp[1] != 0) ? 1 : m_turn;
                    end else begin
                        nxt     = P_AIM;
                        m_turn  = 1 - m_turn;
                        m_force = 0;
`ifdef WIND_RANDOM_EN
                        m_wind = int'(m_lfsr[6:0]) % 101;
`else
                        m_wind = 50;
`endif
                    end
                end
            end
            default: if (start) begin
                nxt = P_IDLE; m_hp[0] = HPI; m_hp[1] = HPI; m_turn = 0; m_win = 0;
            end
        endcase
        if (hit_ok && hit_cat) m_hp[0] = (m_hp[0] > DMG) ? m_hp[0] - DMG : 0;
        if (hit_ok && hit_dog) m_hp[1] = (m_hp[1] > DMG) ? m_hp[1] - DMG : 0;
        m_ph   = nxt;
        m_prev = btn;
        m_lfsr = lfsr_adv(m_lfsr);
    endtask

    task automatic m_compare();
        chk("rnd.en_cat", 32'(enable_cat), 32'(m_ph == P_FLIGHT && m_turn == 0));
        chk("rnd.en_dog", 32'(enable_dog), 32'(m_ph == P_FLIGHT && m_turn == 1));
        chk("rnd.force",  32'(throw_force), m_force);
        chk("rnd.wind",   32'(wind), m_wind);
        chk("rnd.turn",   32'(turn), m_turn);
        chk("rnd.hp_cat", 32'(hp_cat), m_hp[0]);
        chk("rnd.hp_dog", 32'(hp_dog), m_hp[1]);
        chk("rnd.over",   32'(game_over), 32'(m_ph == P_OVER));
        if (m_ph == P_OVER) chk("rnd.winner", 32'(winner), m_win);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit    s, b, dc, dd, hc, hd;
        int    n;
        int    e_force, e_en_cat, e_en_dog, e_turn, e_hpc, e_hpd;
        string tag;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 s b dc dd hc hd  n  force ec ed tn hpc hpd
        tbl.push_back('{1,0,0,0,0,0,  1,    0, 0, 0, 0,100,100, "start_to_aim"});
        tbl.push_back('{0,1,0,0,0,0,  1,    0, 0, 0, 0,100,100, "btn_rise"});
        tbl.push_back('{0,1,0,0,0,0, 30,   15, 0, 0, 0,100,100, "charge_3_ticks"});
        tbl.push_back('{0,0,0,0,0,0,  1,   15, 1, 0, 0,100,100, "release_flight"});
        tbl.push_back('{0,0,0,0,0,1,  1,   15, 1, 0, 0,100, 80, "hit_dog"});
        tbl.push_back('{0,0,1,0,0,0,  1,   15, 0, 0, 0,100, 80, "done_cat"});
        tbl.push_back('{0,0,0,0,0,0,  3,   15, 0, 0, 0,100, 80, "settle_hold"});
        tbl.push_back('{0,0,0,0,0,0,  1,    0, 0, 0, 1,100, 80, "settle_exit"});
        tbl.push_back('{0,1,0,0,0,0,  1,    0, 0, 0, 1,100, 80, "dog_rise"});
        tbl.push_back('{0,1,0,0,0,0, 10,    5, 0, 0, 1,100, 80, "dog_1_tick"});
        tbl.push_back('{0,0,0,0,0,0,  1,    5, 0, 1, 1,100, 80, "dog_flight"});
        tbl.push_back('{0,0,1,0,0,0,  1,    5, 0, 1, 1,100, 80, "inactive_done"});
        tbl.push_back('{0,0,0,0,0,0, 48,    5, 0, 1, 1,100, 80, "flight_49"});
        tbl.push_back('{0,0,0,0,0,0,  1,    5, 0, 0, 1,100, 80, "timeout_50"});
        tbl.push_back('{0,0,0,0,0,0,  4,    0, 0, 0, 0,100, 80, "timeout_settle"});
        tbl.push_back('{0,0,0,0,1,0,  1,    0, 0, 0, 0,100, 80, "hit_in_aim"});

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            set_in(tbl[i].s, tbl[i].b, tbl[i].dc, tbl[i].dd, tbl[i].hc, tbl[i].hd);
            repeat (tbl[i].n) tick();
            chk({tbl[i].tag, ".force"},  32'(throw_force), tbl[i].e_force);
            chk({tbl[i].tag, ".en_cat"}, 32'(enable_cat), tbl[i].e_en_cat);
            chk({tbl[i].tag, ".en_dog"}, 32'(enable_dog), tbl[i].e_en_dog);
            chk({tbl[i].tag, ".turn"},   32'(turn), tbl[i].e_turn);
            chk({tbl[i].tag, ".hp_cat"}, 32'(hp_cat), tbl[i].e_hpc);
            chk({tbl[i].tag, ".hp_dog"}, 32'(hp_dog), tbl[i].e_hpd);
            chk({tbl[i].tag, ".over"},   32'(game_over), 0);
`ifndef WIND_RANDOM_EN
            chk({tbl[i].tag, ".wind"},   32'(wind), 50);
`endif
        end
        set_in(0, 0, 0, 0, 0, 0);

        // force saturation over 301 ticks
        btn = 1'b1;
        tick();
        for (int k = 1; k <= 301 * TICK; k++) begin
            tick();
            chk("sat.force_step", 32'(throw_force),
                ((k / TICK) * FSTEP > FMAX) ? FMAX : (k / TICK) * FSTEP);
        end
        btn = 1'b0;
        tick();
        chk("sat.flight_force", 32'(throw_force), FMAX);
        chk("sat.en_cat", 32'(enable_cat), 1);

        // repeated dog hits saturate at zero, double hit applies both
        for (int k = 1; k <= 5; k++) begin
            hit_dog = 1'b1; tick(); hit_dog = 1'b0;
            chk("hits.hp_dog", 32'(hp_dog), (80 - 20 * k > 0) ? 80 - 20 * k : 0);
        end
        hit_cat = 1'b1; hit_dog = 1'b1; tick(); hit_cat = 1'b0; hit_dog = 1'b0;
        chk("dbl.hp_cat", 32'(hp_cat), 80);
        chk("dbl.hp_dog", 32'(hp_dog), 0);
        done_cat = 1'b1; tick(); done_cat = 1'b0;
        hit_cat = 1'b1; tick();
        chk("settle1_hit.hp_cat", 32'(hp_cat), 60);
        tick(); hit_cat = 1'b0;
        chk("settle2_hit.hp_cat", 32'(hp_cat), 60);
        tick();
        chk("pre_over.over", 32'(game_over), 0);
        tick();
        chk("over.over", 32'(game_over), 1);
        chk("over.winner", 32'(winner), 0);
        chk("over.en_cat", 32'(enable_cat), 0);
        btn = 1'b1; tick(); btn = 1'b0; tick();
        chk("over_btn.over", 32'(game_over), 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart.over", 32'(game_over), 0);
        chk("restart.hp_cat", 32'(hp_cat), HPI);
        chk("restart.hp_dog", 32'(hp_dog), HPI);

        // asynchronous reset in the middle of a flight
        start = 1'b1; tick(); start = 1'b0;
        btn = 1'b1; tick(); repeat (3) tick();
        btn = 1'b0; tick();
        chk("arst.pre_en_cat", 32'(enable_cat), 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        tick();
        m_reset();
        rst = 1'b0;

        // randomized play against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 24) == 0) btn = ~btn;
            start    = ($urandom_range(0, 7) == 0);
            done_cat = ($urandom_range(0, 39) == 0);
            done_dog = ($urandom_range(0, 39) == 0);
            hit_cat  = ($urandom_range(0, 11) == 0);
            hit_dog  = ($urandom_range(0, 11) == 0);
            @(posedge clk);
            m_step();
            #1;
            m_compare();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
